if_axi_rd_bridge: RTL and testbench

//   Responder end of the instruction-fetch request interface. Accepts fetch requests
//   (if_valid/inst_addr/if_size) from the IF stage and issues single-beat AXI4 reads
//   on the instruction port. Returns data/resp to the IF stage with a one-cycle if_ready.

---
 rtl/if_axi_rd_bridge.sv | 111 +++++++++++
 tb/tb_if_axi_rd_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_axi_rd_bridge.sv
// Instruction-fetch responder: turns one IF request into one single-beat AXI4 read
// and hands the aligned, zero-extended data back with a one-cycle if_ready pulse.
module if_axi_rd_bridge #(
   parameter int              ADDR_W = 64,
   parameter int              DATA_W = 64,   // only 64 is supported
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [1:0]        if_size,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              if_ready,
   output logic [1:0]        if_resp,
   output logic [DATA_W-1:0] if_data_read,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [ID_W-1:0]   ar_id,
   output logic [7:0]        ar_len,
   output logic [2:0]        ar_size,
   output logic [1:0]        ar_burst,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   input  logic              r_last,
   input  logic [ID_W-1:0]   r_id
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
   } req_t;

   state_t            state, state_nxt;
   req_t              req_q;
   logic              aligned;
   logic [DATA_W-1:0] beat_shift;
   logic [DATA_W-1:0] beat_mask;

   always_comb begin
      aligned = 1'b1;
      unique case (if_size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~inst_addr[0];
         2'b10:   aligned = (inst_addr[1:0] == 2'b00);
         default: aligned = (inst_addr[2:0] == 3'b000);
      endcase
   end

   // Beat is always full-width; the byte lane comes from the registered low address bits.
   assign beat_shift = r_data >> {req_q.addr[2:0], 3'b000};

   always_comb begin
      beat_mask = '1;
      unique case (req_q.size)
         2'b00:   beat_mask = DATA_W'(64'h0000_0000_0000_00FF);
         2'b01:   beat_mask = DATA_W'(64'h0000_0000_0000_FFFF);
         2'b10:   beat_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
         default: beat_mask = '1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (if_valid) state_nxt = aligned ? ADDR : RESP;
         ADDR: if (ar_ready) state_nxt = DATA;
         DATA: if (r_valid)  state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      req_q <= '0;
      else if (state == IDLE && if_valid) req_q <= '{addr: inst_addr, size: if_size};
   end

   // Misaligned requests report SLVERR without touching the previously returned data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_resp      <= 2'b00;
         if_data_read <= '0;
      end else if (state == IDLE && if_valid && !aligned) begin
         if_resp <= 2'b10;
      end else if (state == DATA && r_valid) begin
         if_data_read <= beat_shift & beat_mask;
         if_resp      <= (!r_last || r_id != AXI_ID) ? 2'b10 : r_resp;
      end
   end

   assign ar_valid = (state == ADDR);
   assign r_ready  = (state == DATA);
   assign if_ready = (state == RESP);
   assign ar_addr  = {req_q.addr[ADDR_W-1:3], 3'b000};
   assign ar_id    = AXI_ID;
   assign ar_len   = 8'd0;
   assign ar_size  = 3'b011;
   assign ar_burst = 2'b01;

endmodule

// File: tb/tb_if_axi_rd_bridge.sv
// Bench for if_axi_rd_bridge: vector table, hand sequences for reset/backpressure/
// back-to-back, and randomized fetches checked against a byte-level reference model.
module tb_if_axi_rd_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [1:0]  if_size = '0;
   logic [63:0] inst_addr = '0;
   logic        if_ready;
   logic [1:0]  if_resp;
   logic [63:0] if_data_read;
   logic        ar_valid;
   logic        ar_ready = 1'b0;
   logic [63:0] ar_addr;
   logic [3:0]  ar_id;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_valid = 1'b0;
   logic        r_ready;
   logic [63:0] r_data = '0;
   logic [1:0]  r_resp = '0;
   logic        r_last = 1'b1;
   logic [3:0]  r_id = '0;

   if_axi_rd_bridge dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_size(if_size), .inst_addr(inst_addr),
      .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .r_id(r_id)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // results of the last fetch
   int          r_lat, r_nar, r_narv, r_nrdy;
   logic [63:0] r_araddr, r_dq;
   logic [1:0]  r_rq;
   logic        r_stable, r_early, r_hold;
   logic [63:0] model_prev = '0;

   typedef struct {
      logic [1:0]  sz;
      logic [63:0] a;
      logic [63:0] d;
      logic [1:0]  rr;
      logic        rl;
      logic [3:0]  id;
      logic [63:0] ed;
      logic [1:0]  er;
      int          el;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Reference: pick bytes (addr%8 .. addr%8+n-1) of the beat; misaligned keeps old data.
   function automatic logic [63:0] m_data(logic [1:0] sz, logic [63:0] a, logic [63:0] d,
                                          logic [63:0] prev);
      int n, off;
      logic [63:0] res;
      n = 1 << sz;
      off = int'(a % 8);
      res = '0;
      if (a % n != 0) return prev;
      for (int i = 0; i < n; i++) res[8*i +: 8] = d[8*(off+i) +: 8];
      return res;
   endfunction

   function automatic logic [1:0] m_resp(logic [1:0] sz, logic [63:0] a, logic [1:0] rr,
                                         logic rl, logic [3:0] id);
      if (a % (1 << sz) != 0) return 2'b10;
      if (!rl || id != 4'd0)  return 2'b10;
      return rr;
   endfunction

   // Drives one request and acts as AXI slave; starts and ends on a negedge.
   task automatic fetch(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] rr, input logic rl, input logic [3:0] id,
                        input int ard, input int rd, input int tail);
      int cyc, arw, rw, end_cyc;
      logic ar_done, r_done, seen_ar;
      logic [63:0] d0;
      logic [1:0]  p0;
      r_lat = -1; r_nar = 0; r_narv = 0; r_nrdy = 0; r_araddr = '0;
      r_stable = 1'b1; r_early = 1'b0; r_hold = 1'b1; r_dq = '0; r_rq = '0;
      arw = 0; rw = 0; ar_done = 1'b0; r_done = 1'b0; seen_ar = 1'b0; end_cyc = 60;
      d0 = if_data_read; p0 = if_resp;
      if_valid = 1'b1; inst_addr = a; if_size = sz;
      r_data = d; r_resp = rr; r_last = rl; r_id = id;
      for (cyc = 1; cyc <= end_cyc; cyc++) begin
         @(posedge clk); @(negedge clk);
         if (if_ready) begin
            r_nrdy++;
            if (r_lat < 0) begin
               r_lat = cyc; r_dq = if_data_read; r_rq = if_resp;
               if_valid = 1'b0; end_cyc = cyc + tail;
            end
         end else if (r_lat < 0) begin
            if (if_data_read !== d0 || if_resp !== p0) r_early = 1'b1;
         end else if (if_data_read !== r_dq || if_resp !== r_rq) begin
            r_hold = 1'b0;
         end
         if (ar_valid) begin
            r_narv++;
            if (seen_ar && ar_addr !== r_araddr) r_stable = 1'b0;
            r_araddr = ar_addr; seen_ar = 1'b1;
            inst_addr = ~a;
         end
         ar_ready = ar_valid && !ar_done && (arw >= ard);
         if (ar_valid) arw++;
         if (ar_done && !r_done) begin
            r_valid = (rw >= rd); rw++;
         end else r_valid = 1'b0;
         if (ar_valid && ar_ready) begin r_nar++; ar_done = 1'b1; end
         if (r_valid && r_ready) r_done = 1'b1;
      end
      ar_ready = 1'b0; r_valid = 1'b0; if_valid = 1'b0;
   endtask

   task automatic run(input string nm, input logic [1:0] sz, input logic [63:0] a,
                      input logic [63:0] d, input logic [1:0] rr, input logic rl,
                      input logic [3:0] id, input int ard, input int rd, input int tail,
                      input logic [63:0] ed, input logic [1:0] er, input int el);
      logic al;
      al = (a % (64'd1 << sz)) == 0;
      fetch(sz, a, d, rr, rl, id, ard, rd, tail);
      chk({nm, ".lat"},   64'(r_lat), 64'(el));
      chk({nm, ".data"},  r_dq, ed);
      chk({nm, ".resp"},  64'(r_rq), 64'(er));
      chk({nm, ".n_ar"},  64'(r_nar), al ? 64'd1 : 64'd0);
      chk({nm, ".arv"},   64'(r_narv), al ? 64'(ard + 1) : 64'd0);
      chk({nm, ".early"}, 64'(r_early), 64'd0);
      if (al) begin
         chk({nm, ".araddr"}, r_araddr, a & ~64'd7);
         chk({nm, ".stable"}, 64'(r_stable), 64'd1);
      end
      if (tail > 0) begin
         chk({nm, ".pulses"}, 64'(r_nrdy), 64'd1);
         chk({nm, ".hold"},   64'(r_hold), 64'd1);
      end
      model_prev = ed;
   endtask

   initial begin
      logic [1:0]  sz, rr, er;
      logic [63:0] a, d, ed;
      logic        rl;
      logic [3:0]  id;
      int          ard, rd, v;

      vt[0] = '{2'b10, 64'h8000_0004, 64'h1234_5678_0000_0013, 2'b00, 1'b1, 4'd0, 64'h0000_0000_1234_5678, 2'b00, 3};
      vt[1] = '{2'b11, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b1, 4'd0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 3};
      vt[2] = '{2'b00, 64'h8000_0007, 64'hAB00_0000_0000_0000, 2'b00, 1'b1, 4'd0, 64'h0000_0000_0000_00AB, 2'b00, 3};
      vt[3] = '{2'b01, 64'h8000_0002, 64'h0000_0000_BEEF_0000, 2'b00, 1'b1, 4'd0, 64'h0000_0000_0000_BEEF, 2'b00, 3};
      vt[4] = '{2'b10, 64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 4'd0, 64'h0000_0000_0000_BEEF, 2'b10, 1};
      vt[5] = '{2'b11, 64'h8000_0010, 64'h0102_0304_0506_0708, 2'b11, 1'b1, 4'd0, 64'h0102_0304_0506_0708, 2'b11, 3};
      vt[6] = '{2'b01, 64'h8000_0006, 64'h5A5A_0000_0000_0000, 2'b00, 1'b0, 4'd0, 64'h0000_0000_0000_5A5A, 2'b10, 3};
      vt[7] = '{2'b00, 64'h8000_0001, 64'h0000_0000_0000_C300, 2'b00, 1'b1, 4'd5, 64'h0000_0000_0000_00C3, 2'b10, 3};
      vt[8] = '{2'b11, 64'h8000_0004, 64'h7777_7777_7777_7777, 2'b00, 1'b1, 4'd0, 64'h0000_0000_0000_00C3, 2'b10, 1};
      vt[9] = '{2'b10, 64'h8000_0000, 64'h1111_2222_3333_4444, 2'b10, 1'b1, 4'd0, 64'h0000_0000_3333_4444, 2'b10, 3};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.ar_valid", 64'(ar_valid), 64'd0);
      chk("rst.r_ready",  64'(r_ready),  64'd0);
      chk("rst.if_ready", 64'(if_ready), 64'd0);
      chk("rst.if_resp",  64'(if_resp),  64'd0);
      chk("rst.data",     if_data_read,  64'd0);
      chk("rst.ar_const", {ar_id, ar_len, ar_size, ar_burst}, {4'd0, 8'd0, 3'b011, 2'b01});
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++)
         run($sformatf("vec%0d", i), vt[i].sz, vt[i].a, vt[i].d, vt[i].rr, vt[i].rl,
             vt[i].id, 0, 0, 2, vt[i].ed, vt[i].er, vt[i].el);

      // backpressure on both channels
      a = 64'h8000_0010; d = 64'h0BAD_F00D_1357_9BDF;
      run("bp", 2'b10, a, d, 2'b00, 1'b1, 4'd0, 5, 4, 2,
          m_data(2'b10, a, d, model_prev), 2'b00, 12);

      // async reset in the middle of the data phase
      if_valid = 1'b1; if_size = 2'b11; inst_addr = 64'h8000_0008; ar_ready = 1'b1;
      r_data = 64'h5555_AAAA_5555_AAAA; r_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      if_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      ar_ready = 1'b0;
      chk("t1.in_data", 64'(r_ready), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1.ar_valid", 64'(ar_valid), 64'd0);
      chk("t1.r_ready",  64'(r_ready),  64'd0);
      chk("t1.if_ready", 64'(if_ready), 64'd0);
      chk("t1.if_resp",  64'(if_resp),  64'd0);
      chk("t1.data",     if_data_read,  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("t1.post%0d", i), {62'd0, ar_valid, if_ready}, 64'd0);
      end
      model_prev = '0;

      // back-to-back: second request waits out the RESP cycle
      run("b2b0", 2'b10, 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b1, 4'd0, 0, 0, 0,
          64'h0000_0000_CCCC_DDDD, 2'b00, 3);
      run("b2b1", 2'b10, 64'h8000_0004, 64'h1111_2222_3333_4444, 2'b00, 1'b1, 4'd0, 0, 0, 2,
          64'h0000_0000_1111_2222, 2'b00, 4);

      // randomized fetches against the reference model
      for (int i = 0; i < 40; i++) begin
         sz  = 2'($urandom_range(0, 3));
         a   = {$urandom(), $urandom()};
         d   = {$urandom(), $urandom()};
         v   = $urandom_range(0, 3);
         rr  = (v == 1) ? 2'b00 : 2'(v);
         rl  = ($urandom_range(0, 7) != 0);
         id  = ($urandom_range(0, 7) == 0) ? 4'd3 : 4'd0;
         ard = $urandom_range(0, 3);
         rd  = $urandom_range(0, 3);
         ed  = m_data(sz, a, d, model_prev);
         er  = m_resp(sz, a, rr, rl, id);
         run($sformatf("rnd%0d", i), sz, a, d, rr, rl, id, ard, rd, 1, ed, er,
             ((a % (64'd1 << sz)) != 0) ? 1 : 3 + ard + rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
